// File: rtl/md_issue.sv
// E-stage issue control for the iterative multiply/divide unit, plus the
// architectural HI/LO registers and mfhi/mflo read-out.
module md_issue #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              e_flush,
  output logic [DATA_W-1:0] D1,
  output logic [DATA_W-1:0] D2,
  output logic              Start,
  output logic              MDSign,
  output logic              MD,
  input  logic              Busy,
  input  logic [DATA_W-1:0] HI,
  input  logic [DATA_W-1:0] LO,
  output logic              stall,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RUN = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d;
  logic [DATA_W-1:0] hi_d, lo_d;
  logic              start_q, start_d;
  logic              sign_q, sign_d;
  logic              md_q, md_d;

  logic md_class, is_mul, is_div, div_zero, accept, launch, capture;

  // Decode; stall depends only on op_valid/op/state so operand forwarding cannot loop.
  always_comb begin
    md_class = (op >= OP_MULT) && (op <= OP_MTLO);
    is_mul   = (op == OP_MULT) || (op == OP_MULTU);
    is_div   = (op == OP_DIV) || (op == OP_DIVU);
    div_zero = is_div && (rt_val == '0);
    stall    = op_valid && md_class && (state_q != IDLE);
    accept   = op_valid && !e_flush && !stall;
    launch   = accept && (state_q == IDLE) && (is_mul || is_div) && !div_zero;
    capture  = (state_q == RUN) && !Busy;
    rd_data  = (op == OP_MFHI) ? hi_q : lo_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      sign_q  <= 1'b0;
      md_q    <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      sign_q  <= sign_d;
      md_q    <= md_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (launch) state_d = ISSUE;
      ISSUE:   state_d = RUN;
      RUN:     if (!Busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Launch operands, completion capture and mthi/mtlo writes.
  always_comb begin
    start_d = launch;
    sign_d  = sign_q;
    md_d    = md_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (launch) begin
      d1_d   = rs_val;
      d2_d   = rt_val;
      sign_d = (op == OP_MULT) || (op == OP_DIV);
      md_d   = is_div;
    end
    if (capture) begin
      hi_d = HI;
      lo_d = LO;
    end else if (accept && (op == OP_MTHI)) begin
      hi_d = rs_val;
    end else if (accept && (op == OP_MTLO)) begin
      lo_d = rs_val;
    end
  end

  assign D1     = d1_q;
  assign D2     = d2_q;
  assign Start  = start_q;
  assign MDSign = sign_q;
  assign MD     = md_q;

endmodule

// File: tb/tb_md_issue.sv
// Bench for md_issue: behavioural MD unit plus arithmetic reference for HI/LO.
module tb_md_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        e_flush;
  logic [31:0] D1, D2;
  logic        Start, MDSign, MD;
  logic        Busy;
  logic [31:0] HI, LO;
  logic        stall;
  logic [31:0] rd_data, hi_q, lo_q;

  int checks = 0;
  int errors = 0;

  md_issue #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .e_flush(e_flush),
    .D1(D1), .D2(D2), .Start(Start), .MDSign(MDSign), .MD(MD),
    .Busy(Busy), .HI(HI), .LO(LO), .stall(stall), .rd_data(rd_data),
    .hi_q(hi_q), .lo_q(lo_q)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: {HI, LO} for mult, {remainder, quotient} for div.
  function automatic logic [63:0] md_calc(input logic dv, input logic sg,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
    if (!dv) begin
      p = sa * sb;
      return 64'(p);
    end
    if (b == 32'd0) return 64'd0;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Behavioural MD unit: Busy rises the cycle after Start, lasts md_lat cycles.
  int          md_lat = 3;
  int          md_rem = 0;
  logic        md_busy = 1'b0;
  logic [31:0] md_hi = 32'd0, md_lo = 32'd0;
  logic [63:0] md_res = 64'd0;
  always @(posedge clk) begin
    if (Start) begin
      md_busy <= 1'b1;
      md_rem  <= md_lat;
      md_res  <= md_calc(MD, MDSign, D1, D2);
      md_hi   <= $urandom;
      md_lo   <= $urandom;
    end else if (md_busy) begin
      if (md_rem == 1) begin
        md_busy <= 1'b0;
        md_hi   <= md_res[63:32];
        md_lo   <= md_res[31:0];
      end else begin
        md_rem <= md_rem - 1;
        md_hi  <= $urandom;
      end
    end
  end
  assign Busy = md_busy;
  assign HI   = md_hi;
  assign LO   = md_lo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one mult/div, follow with an mfhi/mflo and check stall length and capture.
  task automatic run_md(input logic [3:0] mop, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [3:0] fop, input bit flush_mid,
                        output logic [63:0] res);
    int n;
    logic dv, sg;
    dv  = (mop == 4'd3) || (mop == 4'd4);
    sg  = (mop == 4'd1) || (mop == 4'd3);
    res = md_calc(dv, sg, a, b);
    md_lat   = lat;
    op_valid = 1'b1; op = mop; rs_val = a; rt_val = b; e_flush = 1'b0;
    #1 check("stall_at_accept", 32'(stall), 32'd0);
    step();
    op = fop; rs_val = $urandom; rt_val = $urandom;
    #1;
    check("start_pulse", 32'(Start), 32'd1);
    check("d1", D1, a);
    check("d2", D2, b);
    check("mdsign", 32'(MDSign), 32'(sg));
    check("md", 32'(MD), 32'(dv));
    n = 0;
    while (stall === 1'b1 && n < 200) begin
      if (flush_mid) e_flush = 1'($urandom_range(0, 1));
      step();
      n++;
      check("start_single", 32'(Start), 32'd0);
    end
    e_flush = 1'b0;
    #1;
    check("stall_cycles", 32'(n), 32'(lat + 2));
    check("hi_capture", hi_q, res[63:32]);
    check("lo_capture", lo_q, res[31:0]);
    check("rd_data_dep", rd_data, (fop == 4'd5) ? res[63:32] : res[31:0]);
    step();
    op_valid = 1'b0;
  endtask

  logic [63:0] r;

  initial begin
    reset = 1'b0; op_valid = 1'b0; op = 4'd0; rs_val = 32'd0; rt_val = 32'd0; e_flush = 1'b0;
    step(); step();
    op_valid = 1'b1; op = 4'd1;
    #1;
    check("rst_start", 32'(Start), 32'd0);
    check("rst_d1", D1, 32'd0);
    check("rst_hi", hi_q, 32'd0);
    check("rst_lo", lo_q, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    op_valid = 1'b0;
    reset = 1'b1;
    step();

    // MULT -3 * 5
    run_md(4'd1, 32'hFFFF_FFFD, 32'd5, 3, 4'd5, 1'b0, r);
    check("mult_hi_const", hi_q, 32'hFFFF_FFFF);
    check("mult_lo_const", lo_q, 32'hFFFF_FFF1);
    // DIV 85 / 2 then dependent MFHI
    run_md(4'd3, 32'd85, 32'd2, 4, 4'd5, 1'b0, r);
    check("div_lo_const", lo_q, 32'd42);
    check("div_hi_const", hi_q, 32'd1);
    run_md(4'd4, 32'hFFFF_FFFE, 32'd2, 2, 4'd6, 1'b0, r);
    check("divu_lo_const", lo_q, 32'h7FFF_FFFF);
    check("divu_hi_const", hi_q, 32'd0);

    // MTHI / MFHI and MTLO / MFLO
    op_valid = 1'b1; op = 4'd7; rs_val = 32'h1234;
    #1 check("mthi_stall", 32'(stall), 32'd0);
    step();
    op = 4'd5; rs_val = 32'd0;
    #1 check("mfhi_stall", 32'(stall), 32'd0);
    check("mfhi_data", rd_data, 32'h0000_1234);
    op = 4'd8; rs_val = 32'hCAFE_0001;
    step();
    op = 4'd6;
    #1 check("mflo_data", rd_data, 32'hCAFE_0001);
    check("mflo_stall", 32'(stall), 32'd0);

    // DIVU by zero with hi_q = 7
    op = 4'd7; rs_val = 32'd7;
    step();
    op = 4'd4; rs_val = 32'd99; rt_val = 32'd0;
    #1 check("dz_stall0", 32'(stall), 32'd0);
    step();
    op = 4'd5;
    #1 check("dz_start", 32'(Start), 32'd0);
    check("dz_stall1", 32'(stall), 32'd0);
    check("dz_hi", hi_q, 32'd7);
    check("dz_rd", rd_data, 32'd7);

    // Flushed MULT never launches
    op = 4'd1; rs_val = 32'd3; rt_val = 32'd4; e_flush = 1'b1;
    step();
    e_flush = 1'b0; op = 4'd5;
    #1 check("flush_start", 32'(Start), 32'd0);
    check("flush_stall", 32'(stall), 32'd0);
    op_valid = 1'b0;
    step();

    // Flush during RUN does not cancel the capture
    run_md(4'd2, $urandom, $urandom, 5, 4'd6, 1'b1, r);

    // Randomized operations
    for (int i = 0; i < 12; i++) begin
      logic [3:0]  mop;
      logic [31:0] a, b;
      mop = 4'($urandom_range(1, 4));
      a   = $urandom;
      b   = $urandom;
      if (i % 3 == 0) b = 32'($urandom_range(1, 17));
      if (b == 32'd0) b = 32'd1;
      run_md(mop, a, b, $urandom_range(1, 6), 4'($urandom_range(5, 6)),
             1'($urandom_range(0, 1)), r);
    end

    // Reset during RUN abandons the operation
    md_lat = 8;
    op_valid = 1'b1; op = 4'd1; rs_val = 32'd1000; rt_val = 32'd1000;
    step();
    op = 4'd5;
    step(); step(); step();
    #1 check("pre_rst_stall", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    check("rstrun_stall", 32'(stall), 32'd0);
    check("rstrun_start", 32'(Start), 32'd0);
    check("rstrun_hi", hi_q, 32'd0);
    check("rstrun_lo", lo_q, 32'd0);
    op_valid = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) step();
    op_valid = 1'b1; op = 4'd6;
    #1;
    check("late_busy_hi", hi_q, 32'd0);
    check("late_busy_lo", lo_q, 32'd0);
    check("late_busy_stall", 32'(stall), 32'd0);
    op_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
